// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: RUN / DRAIN / HALTED FSM with combinational stage enables.
// Optional performance counters (stall_cnt, flush_cnt) enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  input  logic        halt_id,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    if (!rst_n) begin
      // Outputs follow the asynchronous reset without waiting for a clock edge.
      {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      drain_cnt_d = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (dmem_busy) begin
            {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end else if (imem_busy) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
          end else if (halt_id) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            state_d     = DRAIN;
            drain_cnt_d = 2'd3;
          end
        end
        DRAIN: begin
          if (dmem_busy) begin
            {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
            drain_cnt_d = 2'd0;
          end else begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            // The cycle that takes the counter to zero is the last drain cycle.
            if (drain_cnt_q <= 2'd1) begin
              state_d     = HALTED;
              drain_cnt_d = 2'd0;
            end else begin
              drain_cnt_d = drain_cnt_q - 2'd1;
            end
          end
        end
        HALTED: begin
          {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
          halted = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // A honoured branch is the only case where the PC advances while IF/ID is flushed.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we && (state_q != HALTED) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (pc_we && ifid_flush && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl; perf-counter checks compile in with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use = 1'b0, branch_taken = 1'b0, imem_busy = 1'b0, dmem_busy = 1'b0, halt_id = 1'b0;
  logic pc_we, ifid_we, exmem_we, memwb_we, ifid_flush, idex_bubble, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_id(halt_id),
    .pc_we(pc_we), .ifid_we(ifid_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observed vector: {pc_we, ifid_we, exmem_we, memwb_we, ifid_flush, idex_bubble, halted}
  logic [6:0] obs;
  assign obs = {pc_we, ifid_we, exmem_we, memwb_we, ifid_flush, idex_bubble, halted};

  localparam logic [6:0] O_RUN  = 7'b1111_000;
  localparam logic [6:0] O_DMEM = 7'b0000_000;
  localparam logic [6:0] O_BR   = 7'b1111_110;
  localparam logic [6:0] O_LU   = 7'b0011_010;
  localparam logic [6:0] O_IM   = 7'b0111_100;
  localparam logic [6:0] O_HLT  = 7'b0011_000;
  localparam logic [6:0] O_DRN  = 7'b0011_010;
  localparam logic [6:0] O_HALT = 7'b0000_001;
  localparam logic [6:0] O_RST  = 7'b0000_110;

  // Event vector: {dmem_busy, branch_taken, load_use, imem_busy, halt_id}
  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_HLT  = 5'b00001;
  localparam logic [4:0] EV_IM   = 5'b00010;
  localparam logic [4:0] EV_LU   = 5'b00100;
  localparam logic [4:0] EV_BR   = 5'b01000;
  localparam logic [4:0] EV_DM   = 5'b10000;

  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q[$];
  string      tag_q[$];
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  task automatic check_out();
    logic [6:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
  endtask

  task automatic step(input logic [4:0] ev, input logic [6:0] e, input string tag);
    @(negedge clk);
    {dmem_busy, branch_taken, load_use, imem_busy, halt_id} = ev;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    check_out();
    if (e[6] == 1'b0 && e != O_HALT && exp_stall != 16'hFFFF) exp_stall++;
    if (e == O_BR && exp_flush != 16'hFFFF) exp_flush++;
  endtask

  // Asynchronous reset mid-cycle, immediate output check, then release and first-cycle check.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    {dmem_busy, branch_taken, load_use, imem_busy, halt_id} = EV_NONE;
    exp_q.push_back(O_RST);
    tag_q.push_back({tag, "_in_reset"});
    #1;
    check_out();
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(O_RUN);
    tag_q.push_back({tag, "_first_cycle"});
    #1;
    check_out();
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic check_perf(input string tag);
    @(posedge clk);
    #1;
    tests++;
    assert (stall_cnt === exp_stall) else begin
      fails++;
      $error("FAIL %s_stall: observed %h expected %h", tag, stall_cnt, exp_stall);
    end
    tests++;
    assert (flush_cnt === exp_flush) else begin
      fails++;
      $error("FAIL %s_flush: observed %h expected %h", tag, flush_cnt, exp_flush);
    end
  endtask
`endif

  initial begin
    exp_q.push_back(O_RST);
    tag_q.push_back("reset_state");
    #2;
    check_out();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(O_RUN);
    tag_q.push_back("release_first_cycle");
    #1;
    check_out();
`ifdef PIPE_CTRL_PERF_EN
    check_perf("after_reset");
`endif
    step(EV_NONE, O_RUN, "run_idle");

    step(EV_LU, O_LU, "load_use");
`ifdef PIPE_CTRL_PERF_EN
    check_perf("after_load_use");
`endif
    step(EV_NONE, O_RUN, "load_use_single_bubble");

    step(EV_LU | EV_BR, O_BR, "lu_and_branch");
`ifdef PIPE_CTRL_PERF_EN
    check_perf("after_branch");
`endif
    step(EV_NONE, O_RUN, "after_branch_run");

    for (int i = 0; i < 3; i++) step(EV_DM | EV_LU | EV_BR, O_DMEM, "dmem_freeze");
    step(EV_LU, O_LU, "lu_after_freeze");
    step(EV_NONE, O_RUN, "run_after_lu");

    step(EV_IM, O_IM, "imem_busy");
    step(EV_IM | EV_HLT, O_IM, "imem_over_halt");
    step(EV_NONE, O_RUN, "halt_not_taken");

    // Halt with two frozen cycles in DRAIN: halted 6 cycles after halt_id.
    step(EV_HLT, O_HLT, "halt_id");
    step(EV_NONE, O_DRN, "drain_1");
    step(EV_DM, O_DMEM, "drain_dmem_1");
    step(EV_DM, O_DMEM, "drain_dmem_2");
    step(EV_LU | EV_IM, O_DRN, "drain_2");
    step(EV_NONE, O_DRN, "drain_3");
    step(EV_NONE, O_HALT, "halted_at_6");
    step(EV_BR, O_HALT, "halted_ignores_branch");
    step(EV_NONE, O_HALT, "halted_sticky");
`ifdef PIPE_CTRL_PERF_EN
    check_perf("after_halt");
`endif
    do_reset("reset_from_halted");

    step(EV_HLT, O_HLT, "abort_halt_id");
    step(EV_BR, O_BR, "drain_branch_abort");
    step(EV_NONE, O_RUN, "abort_back_in_run");
    step(EV_NONE, O_RUN, "abort_still_run");

    step(EV_HLT, O_HLT, "mid_drain_halt_id");
    step(EV_NONE, O_DRN, "mid_drain");
    do_reset("reset_mid_drain");
    step(EV_NONE, O_RUN, "run_after_drain_reset");

`ifdef PIPE_CTRL_PERF_EN
    step(EV_BR, O_BR, "branch_before_sat");
    @(negedge clk);
    {dmem_busy, branch_taken, load_use, imem_busy, halt_id} = EV_IM;
    repeat (65600) @(posedge clk);
    exp_stall = 16'hFFFF;
    check_perf("saturation");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: load_use  in  1  load-use hazard between ID/EX destination and IF/ID sources.
REQ-004 SHALL have: branch_taken  in  1  branch/BR resolved taken in EX this cycle.
REQ-005 SHALL have: imem_busy  in  1  instruction fetch not complete this cycle.
REQ-006 SHALL have: dmem_busy  in  1  data access in MEM not complete this cycle.
REQ-007 SHALL have: halt_id  in  1  HLT opcode decoded in ID.
REQ-008 SHALL have outputs pc_we, ifid_we, exmem_we, memwb_we  out  1 each  stage-register write enables.
REQ-009 SHALL have: ifid_flush  out  1  load NOP into IF/ID when ifid_we=1.
REQ-010 SHALL have: idex_bubble  out  1  load NOP (all control zero) into ID/EX.
REQ-011 SHALL have: halted  out  1  pipeline drained after HLT.

Function
REQ-012 SHALL implement FSM states RUN, DRAIN, HALTED; outputs are combinational from state and inputs, with zero-cycle latency.
REQ-013 In RUN with no events, all write enables SHALL be 1 and ifid_flush = idex_bubble = 0.
REQ-014 Priority, highest first: dmem_busy, branch_taken, load_use, imem_busy, halt_id.
REQ-015 dmem_busy=1 SHALL drive all write enables to 0 and ifid_flush = idex_bubble = 0, freezing the whole pipeline; all other events are ignored that cycle.
REQ-016 branch_taken=1 (no dmem_busy) SHALL give pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, exmem_we=memwb_we=1; load_use is ignored.
REQ-017 load_use=1 (no higher event) SHALL give pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=memwb_we=1, which inserts exactly one bubble per asserted cycle.
REQ-018 imem_busy=1 (no higher event) SHALL give pc_we=0, ifid_we=1, ifid_flush=1, with downstream stages advancing.
REQ-019 halt_id=1 in RUN (no higher event) SHALL give pc_we=0, ifid_we=0, idex_bubble=0, and the next state SHALL be DRAIN with a 2-bit drain counter loaded to 3.
REQ-020 In DRAIN, pc_we=ifid_we=0 and idex_bubble=1; the counter SHALL decrement only on cycles without dmem_busy, and the FSM SHALL enter HALTED when the counter is 0.
REQ-021 branch_taken during DRAIN SHALL abort the halt: the next state is RUN, with REQ-016 outputs.
REQ-022 In HALTED, all write enables SHALL be 0 and halted=1; the FSM SHALL leave HALTED only through reset.

Reset
REQ-023 When rst_n=0: state=RUN, drain counter=0, pc_we=ifid_we=exmem_we=memwb_we=0, ifid_flush=idex_bubble=1, halted=0, and all counters =0.
REQ-024 Reset asserted mid-DRAIN or in HALTED SHALL take effect immediately (asynchronous); the first cycle after deassertion behaves as RUN.

Configuration
REQ-025 When macro PIPE_CTRL_PERF_EN is defined, outputs stall_cnt and flush_cnt (out, 16 bits each) SHALL exist.
REQ-026 stall_cnt SHALL increment on each cycle with pc_we=0 in RUN or DRAIN.
REQ-027 flush_cnt SHALL increment on each cycle with branch_taken honoured.
REQ-028 Both counters SHALL saturate at 16'hFFFF.
REQ-029 Without PIPE_CTRL_PERF_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset release, no events -> all write enables 1, flush/bubble 0 from the first cycle.
REQ-031 load_use for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1.
REQ-032 load_use and branch_taken in the same cycle -> ifid_flush=1, idex_bubble=1, pc_we=1; flush_cnt=1, stall_cnt unchanged.
REQ-033 dmem_busy for 3 cycles with load_use held -> all enables 0 for 3 cycles, then a single load-use bubble.
REQ-034 halt_id, then dmem_busy for 2 cycles during DRAIN -> halted=1 exactly 6 cycles after halt_id, and stays 1 until rst_n pulse.
REQ-035 With the counters forced near FFFF by a long imem_busy run -> stall_cnt holds at 16'hFFFF.
